// File: rtl/corefifo_wr_gray_ptr_gen.sv
// rtl/corefifo_wr_gray_ptr_gen.sv - write-domain pointer, gray CDC source and full/afull/count flags
// All state is registered so the gray pointer leaving this domain is glitch-free.
module corefifo_wr_gray_ptr_gen #(
  parameter int ADDRWIDTH    = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 srstn,
  input  logic                 we,
  input  logic [ADDRWIDTH:0]   rd_ptr_gray_sync,
  output logic [ADDRWIDTH:0]   wr_ptr_gray,
  output logic [ADDRWIDTH-1:0] waddr,
  output logic                 wen_mem,
  output logic                 full,
  output logic                 afull,
  output logic [ADDRWIDTH:0]   wr_cnt,
  output logic                 overflow
);

  localparam int PW = ADDRWIDTH + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rgray_full;
  logic [PW-1:0] cnt_next;

  assign wen_mem    = we & ~full;
  assign waddr      = wbin[ADDRWIDTH-1:0];
  assign wbin_next  = wbin + {{ADDRWIDTH{1'b0}}, wen_mem};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);

  // Gray to binary: each bit is the XOR of all gray bits at or above it.
  always_comb begin
    rbin = '0;
    rbin[PW-1] = rd_ptr_gray_sync[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ rd_ptr_gray_sync[i];
    end
  end

  // Full when the write gray pointer equals the read gray pointer with its top two bits inverted.
  assign rgray_full = {~rd_ptr_gray_sync[PW-1:PW-2], rd_ptr_gray_sync[PW-3:0]};
  assign cnt_next   = wbin_next - rbin;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wbin        <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      afull       <= 1'b0;
      wr_cnt      <= '0;
      overflow    <= 1'b0;
    end else if (!srstn) begin
      wbin        <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      afull       <= 1'b0;
      wr_cnt      <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wr_ptr_gray <= wgray_next;
      full        <= (wgray_next == rgray_full);
      afull       <= (cnt_next >= AFULL_LVL);
      wr_cnt      <= cnt_next;
      overflow    <= we & full;
    end
  end

endmodule
